proc_ctrl_unit: RTL and testbench

Multicycle control unit for the 16-bit processor. It sequences the shared bus datapath (R0–R7, A, G, IR, ADDR, DOUT, W) through fetch and execute steps, decodes the instruction register, and drives all register-enable and bus-select strobes. It sits inside the processor next to the datapath. It reports progress on `Tstep_Q` and `Done`, which the board top shows on HEX6 and LEDR[17].

---
 rtl/proc_ctrl_pkg.sv | 37 +++
 rtl/proc_ctrl_unit_if.sv | 32 +++
 rtl/proc_ctrl_unit_dec3to8.sv | 7 +
 rtl/proc_ctrl_unit.sv | 99 +++++++++
 tb/tb_proc_ctrl_unit.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, step encodings and ALU codes.
package proc_ctrl_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstep_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_t;

  // Step in which an opcode raises Done; mvnz and the unused opcodes finish in T3 either way.
  function automatic tstep_t last_step(input logic [3:0] op);
    case (op)
      OP_ST:                                 last_step = T4;
      OP_MVI, OP_LD, OP_ADD, OP_SUB, OP_AND: last_step = T5;
      default:                               last_step = T3;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_unit_if.sv
// Control-unit to datapath bundle: the control unit is the master driving all strobes.
interface proc_ctrl_unit_if;
  logic       Run;
  logic [9:0] IR;
  logic       Gnz;
  logic [2:0] Tstep_Q;
  logic       Done;
  logic [7:0] Rout;
  logic [7:0] Rin;
  logic       Gout;
  logic       DINout;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       ADDRin;
  logic       DOUTin;
  logic       incr_pc;
  logic       W_D;
  logic [1:0] AluOp;

  modport master (
    input  Run, IR, Gnz,
    output Tstep_Q, Done, Rout, Rin, Gout, DINout, IRin, Ain, Gin,
           ADDRin, DOUTin, incr_pc, W_D, AluOp
  );

  modport slave (
    output Run, IR, Gnz,
    input  Tstep_Q, Done, Rout, Rin, Gout, DINout, IRin, Ain, Gin,
           ADDRin, DOUTin, incr_pc, W_D, AluOp
  );
endinterface

// File: rtl/proc_ctrl_unit_dec3to8.sv
// 3-to-8 one-hot decoder used for the Rx and Ry register selects.
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);
  assign onehot = 8'b1 << sel;
endmodule

// File: rtl/proc_ctrl_unit.sv
// Multicycle control unit sequencing fetch/execute steps of the 16-bit processor.
// Build option: define CTRL_MVNZ_EN to execute opcode 6 as mvnz; otherwise it is a NOP.
import proc_ctrl_pkg::*;

module proc_ctrl_unit (
  input  logic Clock,
  input  logic Resetn,
  proc_ctrl_unit_if.master bus
);

  tstep_t     state, next_state, done_step;
  logic [3:0] opcode;
  logic [7:0] x_sel, y_sel;

  assign opcode    = bus.IR[9:6];
  assign done_step = last_step(opcode);
  assign bus.Tstep_Q = state;

  dec3to8 u_dec_x (.sel(bus.IR[5:3]), .onehot(x_sel));
  dec3to8 u_dec_y (.sel(bus.IR[2:0]), .onehot(y_sel));

`ifndef CTRL_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = bus.Gnz;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= T0;
    else         state <= next_state;
  end

  // Encodings 6 and 7 fall through to the default and recover to T0.
  always_comb begin
    next_state = T0;
    case (state)
      T0:      next_state = bus.Run ? T1 : T0;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = (done_step == T3) ? T0 : T4;
      T4:      next_state = (done_step == T4) ? T0 : T5;
      default: next_state = T0;
    endcase
  end

  // Strobes are gated by Resetn so nothing leaks out while reset is held with Run high.
  always_comb begin
    bus.Done    = 1'b0;
    bus.Rout    = 8'h00;
    bus.Rin     = 8'h00;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.ADDRin  = 1'b0;
    bus.DOUTin  = 1'b0;
    bus.incr_pc = 1'b0;
    bus.W_D     = 1'b0;
    bus.AluOp   = ALU_ADD;
    if (Resetn) begin
      case (state)
        T0: if (bus.Run) begin
          bus.Rout    = 8'h80;
          bus.ADDRin  = 1'b1;
          bus.incr_pc = 1'b1;
        end
        T2: bus.IRin = 1'b1;
        T3: case (opcode)
          OP_MV:  begin bus.Rout = y_sel; bus.Rin = x_sel; end
          OP_MVI: begin bus.Rout = 8'h80; bus.ADDRin = 1'b1; bus.incr_pc = 1'b1; end
          OP_ADD, OP_SUB, OP_AND: begin bus.Rout = x_sel; bus.Ain = 1'b1; end
          OP_LD, OP_ST: begin bus.Rout = y_sel; bus.ADDRin = 1'b1; end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: if (bus.Gnz) begin bus.Rout = y_sel; bus.Rin = x_sel; end
`endif
          default: ;
        endcase
        T4: case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.Rout  = y_sel;
            bus.Gin   = 1'b1;
            bus.AluOp = (opcode == OP_SUB) ? ALU_SUB :
                        (opcode == OP_AND) ? ALU_AND : ALU_ADD;
          end
          OP_ST: begin bus.Rout = x_sel; bus.DOUTin = 1'b1; bus.W_D = 1'b1; end
          default: ;
        endcase
        T5: case (opcode)
          OP_MVI, OP_LD: begin bus.DINout = 1'b1; bus.Rin = x_sel; end
          OP_ADD, OP_SUB, OP_AND: begin bus.Gout = 1'b1; bus.Rin = x_sel; end
          default: ;
        endcase
        default: ;
      endcase
      bus.Done = (state == done_step);
    end
  end

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle outputs, a negedge monitor compares them.
module tb_proc_ctrl_unit;

  typedef struct packed {
    logic [2:0] t;
    logic       done;
    logic [7:0] rout;
    logic [7:0] rin;
    logic [8:0] fl;
    logic [1:0] alu;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  // Flag order: Gout, DINout, IRin, Ain, Gin, ADDRin, DOUTin, incr_pc, W_D
  localparam logic [8:0] F_GOUT = 9'h100;
  localparam logic [8:0] F_DIN  = 9'h080;
  localparam logic [8:0] F_IRIN = 9'h040;
  localparam logic [8:0] F_AIN  = 9'h020;
  localparam logic [8:0] F_GIN  = 9'h010;
  localparam logic [8:0] F_ADDR = 9'h008;
  localparam logic [8:0] F_DOUT = 9'h004;
  localparam logic [8:0] F_INC  = 9'h002;
  localparam logic [8:0] F_WD   = 9'h001;

  logic Clock;
  logic Resetn;
  proc_ctrl_unit_if bus();

  proc_ctrl_unit dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  exp_t sb[$];
  exp_t cur;
  obs_t act;
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic obs_t ob(input logic [2:0] t, input logic d, input logic [7:0] rout,
                              input logic [7:0] rin, input logic [8:0] fl, input logic [1:0] alu);
    obs_t o;
    o.t = t; o.done = d; o.rout = rout; o.rin = rin; o.fl = fl; o.alu = alu;
    return o;
  endfunction

  task automatic checkOutput();
    cur = sb.pop_front();
    act = ob(bus.Tstep_Q, bus.Done, bus.Rout, bus.Rin,
             {bus.Gout, bus.DINout, bus.IRin, bus.Ain, bus.Gin,
              bus.ADDRin, bus.DOUTin, bus.incr_pc, bus.W_D}, bus.AluOp);
    n_checks++;
    if (act !== cur.v) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", cur.name, act, cur.v);
    end
  endtask

  always @(negedge Clock) if (sb.size() > 0) checkOutput();

  task automatic applyStimulus(input string name, input logic run, input logic [9:0] ir,
                               input logic gnz, input obs_t e);
    @(posedge Clock);
    #1;
    bus.Run = run;
    bus.IR  = ir;
    bus.Gnz = gnz;
    sb.push_back('{name, e});
  endtask

  task automatic fetch(input string name, input logic [9:0] ir, input logic gnz);
    applyStimulus({name, "_t0"}, 1'b1, ir, gnz, ob(3'd0, 0, 8'h80, 8'h00, F_ADDR | F_INC, 2'b00));
    applyStimulus({name, "_t1"}, 1'b0, ir, gnz, ob(3'd1, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    applyStimulus({name, "_t2"}, 1'b0, ir, gnz, ob(3'd2, 0, 8'h00, 8'h00, F_IRIN, 2'b00));
  endtask

  task automatic idle(input string name);
    applyStimulus(name, 1'b0, 10'h000, 1'b0, ob(3'd0, 0, 8'h00, 8'h00, 9'h000, 2'b00));
  endtask

  task automatic alu_instr(input string name, input logic [9:0] ir, input logic [1:0] alu);
    fetch(name, ir, 1'b0);
    applyStimulus({name, "_t3"}, 1'b0, ir, 1'b0, ob(3'd3, 0, 8'h02, 8'h00, F_AIN, 2'b00));
    applyStimulus({name, "_t4"}, 1'b0, ir, 1'b0, ob(3'd4, 0, 8'h08, 8'h00, F_GIN, alu));
    applyStimulus({name, "_t5"}, 1'b0, ir, 1'b0, ob(3'd5, 1, 8'h00, 8'h02, F_GOUT, 2'b00));
  endtask

  initial begin
    Resetn = 1'b0;
    bus.Run = 1'b0; bus.IR = 10'h000; bus.Gnz = 1'b0;

    // Outputs stay quiet under reset even with Run asserted
    applyStimulus("rst_run1", 1'b1, 10'h000, 1'b0, ob(3'd0, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    applyStimulus("rst_run0", 1'b0, 10'h000, 1'b0, ob(3'd0, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) idle("idle_t0");

    // mv R2,R5
    fetch("mv", 10'h015, 1'b0);
    applyStimulus("mv_t3", 1'b0, 10'h015, 1'b0, ob(3'd3, 1, 8'h20, 8'h04, 9'h000, 2'b00));
    idle("mv_after");

    alu_instr("add", 10'h08B, 2'b00);
    alu_instr("sub", 10'h0CB, 2'b01);
    alu_instr("and", 10'h1CB, 2'b10);
    idle("alu_after");

    // st R4,R6
    fetch("st", 10'h166, 1'b0);
    applyStimulus("st_t3", 1'b0, 10'h166, 1'b0, ob(3'd3, 0, 8'h40, 8'h00, F_ADDR, 2'b00));
    applyStimulus("st_t4", 1'b0, 10'h166, 1'b0, ob(3'd4, 1, 8'h10, 8'h00, F_DOUT | F_WD, 2'b00));
    idle("st_after");

    // mvi R3
    fetch("mvi", 10'h058, 1'b0);
    applyStimulus("mvi_t3", 1'b0, 10'h058, 1'b0, ob(3'd3, 0, 8'h80, 8'h00, F_ADDR | F_INC, 2'b00));
    applyStimulus("mvi_t4", 1'b0, 10'h058, 1'b0, ob(3'd4, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    applyStimulus("mvi_t5", 1'b0, 10'h058, 1'b0, ob(3'd5, 1, 8'h00, 8'h08, F_DIN, 2'b00));

    // mvnz R0,R1 with Gnz low then high
    fetch("mvnz_g0", 10'h181, 1'b0);
    applyStimulus("mvnz_g0_t3", 1'b0, 10'h181, 1'b0, ob(3'd3, 1, 8'h00, 8'h00, 9'h000, 2'b00));
    fetch("mvnz_g1", 10'h181, 1'b1);
`ifdef CTRL_MVNZ_EN
    applyStimulus("mvnz_g1_t3", 1'b0, 10'h181, 1'b1, ob(3'd3, 1, 8'h02, 8'h01, 9'h000, 2'b00));
`else
    applyStimulus("mvnz_g1_t3", 1'b0, 10'h181, 1'b1, ob(3'd3, 1, 8'h00, 8'h00, 9'h000, 2'b00));
`endif
    idle("mvnz_after");

    // ld R1,R2 complete
    fetch("ld", 10'h10A, 1'b0);
    applyStimulus("ld_t3", 1'b0, 10'h10A, 1'b0, ob(3'd3, 0, 8'h04, 8'h00, F_ADDR, 2'b00));
    applyStimulus("ld_t4", 1'b0, 10'h10A, 1'b0, ob(3'd4, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    applyStimulus("ld_t5", 1'b0, 10'h10A, 1'b0, ob(3'd5, 1, 8'h00, 8'h02, F_DIN, 2'b00));
    idle("ld_after");

    // ld aborted by reset in T4
    fetch("ldrst", 10'h10A, 1'b0);
    applyStimulus("ldrst_t3", 1'b0, 10'h10A, 1'b0, ob(3'd3, 0, 8'h04, 8'h00, F_ADDR, 2'b00));
    @(posedge Clock);
    #1;
    bus.Run = 1'b1;
    Resetn  = 1'b0;
    sb.push_back('{"ldrst_abort", ob(3'd0, 0, 8'h00, 8'h00, 9'h000, 2'b00)});
    applyStimulus("ldrst_held", 1'b0, 10'h10A, 1'b0, ob(3'd0, 0, 8'h00, 8'h00, 9'h000, 2'b00));
    Resetn = 1'b1;
    idle("ldrst_after");

    // Opcode 0xF behaves as NOP
    fetch("nop", 10'h3C0, 1'b0);
    applyStimulus("nop_t3", 1'b0, 10'h3C0, 1'b0, ob(3'd3, 1, 8'h00, 8'h00, 9'h000, 2'b00));
    idle("nop_after");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clock);
    #1;
    if (sb.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
